// File: rtl/adc_conv_ctrl.sv
// adc_conv_ctrl: SAR ADC conversion sequencer (single-shot or periodic) with a result FIFO.
// Define ADC_CTRL_TIMEOUT_EN to add the CONV-state timeout counter and the sticky tmo flag.
module adc_conv_ctrl #(
    parameter int SAMPLE_CYCLES  = 4,
    parameter int PERIOD_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clkin,
    input  logic                        rst,
    input  logic                        cont_en,
    input  logic                        trig,
    output logic                        st_conv,
    input  logic                        adc_done,
    input  logic [11:0]                 adc_result,
    output logic [11:0]                 rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        ovf,
    output logic                        tmo,
    input  logic                        clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SAMPLE_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, CONV, STORE, GAP} state_t;

    state_t        state;
    logic [SW-1:0] scnt;
    logic [PW-1:0] pcnt;
    logic [2:0]    sync;
    logic          done_rise, start, tmo_hit;
    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp, rp_n;
    logic [AW:0]   level_n;
    logic          push_req, push, pop, full;

    // sync[1:0] is the two-flop synchronizer, sync[2] only delays for edge detection
    always_ff @(posedge clkin or posedge rst)
        if (rst) sync <= '0;
        else sync <= {sync[1:0], adc_done};

    assign done_rise = sync[1] & ~sync[2];
    assign busy      = state != IDLE;
    // an overrun period is already expired in STORE, so SAMPLE follows STORE directly
    assign start     = (state == IDLE && (cont_en || trig)) ||
                       ((state == STORE || state == GAP) && cont_en && pcnt == '0);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            st_conv <= 1'b0;
            scnt    <= '0;
            pcnt    <= '0;
        end else begin
            if (pcnt != '0) pcnt <= pcnt - 1'b1;
            if (start) begin
                state   <= SAMPLE;
                st_conv <= 1'b1;
                scnt    <= SW'(SAMPLE_CYCLES - 1);
                pcnt    <= PW'(PERIOD_CYCLES - 1);
            end else case (state)
                SAMPLE: if (scnt == '0) begin
                    state   <= CONV;
                    st_conv <= 1'b0;
                end else scnt <= scnt - 1'b1;
                CONV:    state <= done_rise ? STORE : tmo_hit ? GAP : CONV;
                STORE:   state <= GAP;
                GAP:     state <= cont_en ? GAP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    assign tmo_hit = state == CONV && !done_rise && tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clkin or posedge rst)
        if (rst) begin
            tcnt <= '0;
            tmo  <= 1'b0;
        end else begin
            tcnt <= (state == CONV) ? tcnt + 1'b1 : '0;
            tmo  <= tmo_hit | (tmo & ~clr_err);
        end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign tmo_hit        = 1'b0;
    assign tmo            = 1'b0;
`endif

    // a pop frees the slot before the push, so a full FIFO still accepts
    assign full     = fifo_level == (AW+1)'(FIFO_DEPTH);
    assign push_req = state == STORE;
    assign pop      = rd_valid & rd_ready;
    assign push     = push_req & (~full | pop);
    assign rp_n     = rp + AW'(pop);
    assign level_n  = fifo_level + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clkin)
        if (push) mem[wp] <= adc_result;

    always_ff @(posedge clkin or posedge rst)
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            ovf        <= 1'b0;
        end else begin
            wp         <= wp + AW'(push);
            rp         <= rp_n;
            fifo_level <= level_n;
            rd_valid   <= level_n != '0;
            rd_data    <= (fifo_level == (AW+1)'(pop)) ? adc_result : mem[rp_n];
            ovf        <= (push_req & ~push) | (ovf & ~clr_err);
        end
endmodule
